// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
// Optional pattern masking is enabled with the SEQ_DET_MASK_EN macro.
package seq_det_pkg;

  localparam logic [1:0] MODE_MOORE_OV  = 2'b00;
  localparam logic [1:0] MODE_MOORE_NOV = 2'b01;
  localparam logic [1:0] MODE_MEALY_OV  = 2'b10;
  localparam logic [1:0] MODE_MEALY_NOV = 2'b11;

  // Explicit encodings keep the legacy LOAD=0 / RUN=1 state values.
  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic mode_is_mealy(input logic [1:0] m);
    return m[1];
  endfunction

  function automatic logic mode_is_nov(input logic [1:0] m);
    return m[0];
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// Shift window, fill counter and pattern compare for seq_detector_param.
// SEQ_DET_MASK_EN adds a don't-care mask input to the compare.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sample,
  input  logic             i_flush,
  input  logic             i_nov,
  input  logic             i_data,
  input  logic [PAT_W-1:0] i_pattern,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] i_mask,
`endif
  output logic             o_hit
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  r_hist;
  logic [PAT_W-1:0]  w_hist_n;
  logic [PAT_W-1:0]  w_diff;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_n;

  always_comb begin
    w_hist_n = {r_hist[PAT_W-2:0], i_data};
    w_fill_n = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
`ifdef SEQ_DET_MASK_EN
    w_diff   = (w_hist_n ^ i_pattern) & ~i_mask;
`else
    w_diff   = w_hist_n ^ i_pattern;
`endif
    o_hit    = i_sample && (w_fill_n == FILL_FULL) && (w_diff == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_flush) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_sample) begin
      r_hist <= w_hist_n;
      r_fill <= (o_hit && i_nov) ? '0 : w_fill_n;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with runtime pattern and mode.
// SEQ_DET_MASK_EN adds the pat_mask don't-care input.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned         PAT_W       = 5,
  parameter logic [PAT_W-1:0]    DEFAULT_PAT = PAT_W'(5'b10101),
  parameter int unsigned         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic             data,
  input  logic [1:0]       mode,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask,
`endif
  output logic             detected,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic             r_moore_q;
  logic [CNT_W-1:0] r_count;
  logic             w_sample;
  logic             w_hit;

  // A load cycle discards its own sample; LOAD itself samples normally.
  assign w_sample = data_valid && !pat_load;

  seq_det_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .i_sample  (w_sample),
    .i_flush   (pat_load),
    .i_nov     (mode_is_nov(mode)),
    .i_data    (data),
    .i_pattern (r_pattern),
`ifdef SEQ_DET_MASK_EN
    .i_mask    (pat_mask),
`endif
    .o_hit     (w_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        LOAD:    r_state <= pat_load ? LOAD : RUN;
        default: r_state <= pat_load ? LOAD : RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pattern <= DEFAULT_PAT;
    end else if (pat_load) begin
      r_pattern <= pat_in;
    end
  end

  // Only loaded in Moore mode, so a switch to Mealy shows a pending pulse once.
  always_ff @(posedge clk) begin
    if (!rst || pat_load) begin
      r_moore_q <= 1'b0;
    end else begin
      r_moore_q <= w_hit && !mode_is_mealy(mode);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      r_count <= '0;
    end else if (w_hit && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    detected = 1'b0;
    if (rst) begin
      detected = mode_is_mealy(mode) ? (w_hit | r_moore_q) : r_moore_q;
    end
  end

  assign match_count = r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: queue-based reference model,
// directed scenarios then randomized traffic.
module tb_seq_detector_param;

  localparam int unsigned PAT_W   = 5;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [PAT_W-1:0] DEF_PAT = 5'b10101;

  logic             clk = 1'b0;
  logic             rst;
  logic             data_valid;
  logic             data;
  logic [1:0]       mode;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic [PAT_W-1:0] pat_mask;
  logic             detected;
  logic [CNT_W-1:0] match_count;

  seq_detector_param #(
    .PAT_W       (PAT_W),
    .DEFAULT_PAT (DEF_PAT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_valid  (data_valid),
    .data        (data),
    .mode        (mode),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .cnt_clr     (cnt_clr),
`ifdef SEQ_DET_MASK_EN
    .pat_mask    (pat_mask),
`endif
    .detected    (detected),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          det;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   drv_done = 0;

  // Reference model: accepted bits since the last flush, newest at the back.
  bit               m_bits[$];
  logic [PAT_W-1:0] m_pat   = DEF_PAT;
  bit               m_moore = 0;
  int unsigned      m_cnt   = 0;
  logic [PAT_W-1:0] cur_mask = '0;

  function automatic bit win_match(input bit b[$], input logic [PAT_W-1:0] pat,
                                   input logic [PAT_W-1:0] msk);
    for (int i = 0; i < PAT_W; i++) begin
      int unsigned pos;
      pos = PAT_W - 1 - i;
      if (!msk[pos] && (b[b.size() - PAT_W + i] != pat[pos])) return 0;
    end
    return 1;
  endfunction

  task automatic cyc(input logic r, input logic dv, input logic d, input logic [1:0] m,
                     input logic ld, input logic [PAT_W-1:0] pin, input logic clr);
    bit   tmp[$];
    bit   hit;
    exp_t e;
    rst = r; data_valid = dv; data = d; mode = m;
    pat_load = ld; pat_in = pin; cnt_clr = clr; pat_mask = cur_mask;
    tmp = m_bits;
    tmp.push_back(d);
    hit = r && !ld && dv && (tmp.size() >= PAT_W) && win_match(tmp, m_pat, cur_mask);
    e.det = r && (m[1] ? (hit || m_moore) : m_moore);
    e.cnt = m_cnt;
    sb.push_back(e);
    if (!r) begin
      m_pat = DEF_PAT; m_bits.delete(); m_moore = 0; m_cnt = 0;
    end else begin
      if (ld) begin
        m_pat = pin; m_bits.delete();
      end else if (dv) begin
        m_bits = tmp;
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        if (hit && m[0]) m_bits.delete();
      end
      m_moore = hit && !m[1] && !ld;
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic stream(input logic [31:0] bits, input int n, input logic [1:0] m);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'b1, bits[i], m, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input logic [1:0] m);
    cyc(1'b1, 1'b0, 1'b0, m, 1'b0, '0, 1'b0);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [1:0] m);
    cyc(1'b1, 1'b0, 1'b0, m, 1'b1, p, 1'b1);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: every cycle the DUT presents detected/match_count.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (detected !== e.det) begin
          n_fail++;
          $display("FAIL detected @%0t: got %b expected %b", $time, detected, e.det);
        end
        n_checks++;
        if (match_count !== CNT_W'(e.cnt)) begin
          n_fail++;
          $display("FAIL match_count @%0t: got %0d expected %0d", $time, match_count, e.cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]       rm;
    logic [PAT_W-1:0] rp;
    rst = 0; data_valid = 0; data = 0; mode = 2'b00;
    pat_load = 0; pat_in = '0; cnt_clr = 0; pat_mask = '0;
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, '0, 1'b0);

    // Moore overlap on alternating stream.
    stream(32'b1010101010101, 13, 2'b00);
    idle(2'b00);
    chk("moore_ov_count", int'(match_count), 5);

    // Non-overlap, Moore then Mealy.
    load(DEF_PAT, 2'b01);
    stream(32'b1010101010101, 13, 2'b01);
    idle(2'b01);
    chk("moore_nov_count", int'(match_count), 2);
    load(DEF_PAT, 2'b11);
    stream(32'b1010101010101, 13, 2'b11);
    chk("mealy_nov_count", int'(match_count), 2);

    // Gaps inside a Mealy match.
    load(DEF_PAT, 2'b10);
    stream(32'b101, 3, 2'b10);
    repeat (3) idle(2'b10);
    stream(32'b01, 2, 2'b10);
    chk("gap_count", int'(match_count), 1);

    // Load with a coincident valid sample, then overlapping repeat.
    cyc(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 5'b10011, 1'b1);
    stream(32'b10011, 5, 2'b00);
    stream(32'b10011, 5, 2'b00);
    idle(2'b00);
    chk("load_count", int'(match_count), 2);

    // Saturation, then clear coincident with a hit.
    load(DEF_PAT, 2'b00);
    stream(32'b10101010101010101010101, 23, 2'b00);
    chk("sat_count", int'(match_count), CNT_MAX);
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, '0, 1'b1);
    chk("clr_vs_hit", int'(match_count), 0);

    // Reset mid-sequence, Mealy so a stray hit would show immediately.
    stream(32'b1010, 4, 2'b10);
    cyc(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, '0, 1'b0);
    stream(32'b1, 1, 2'b10);
    chk("reset_no_hit", int'(match_count), 0);
    stream(32'b10101, 5, 2'b10);
    chk("post_reset_count", int'(match_count), 1);

    // Moore pulse pending while switching to Mealy.
    load(DEF_PAT, 2'b00);
    stream(32'b10101, 5, 2'b00);
    idle(2'b10);
    idle(2'b10);

`ifdef SEQ_DET_MASK_EN
    load(DEF_PAT, 2'b10);
    cur_mask = 5'b00100;
    stream(32'b10001, 5, 2'b10);
    chk("mask_count", int'(match_count), 1);
    cur_mask = '0;
`endif

    // Randomized traffic.
    rm = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) rm = 2'($urandom_range(0, 3));
`ifdef SEQ_DET_MASK_EN
      if ($urandom_range(0, 49) == 0) cur_mask = ($urandom_range(0, 3) == 0) ? PAT_W'($urandom) : '0;
`endif
      rp = ($urandom_range(0, 1) == 0) ? DEF_PAT : PAT_W'($urandom);
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom),
          rm,
          ($urandom_range(0, 59) == 0),
          rp,
          ($urandom_range(0, 99) == 0));
    end
    idle(rm);
    drv_done = 1;

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
